// File: rtl/nibble_pkg.sv
// nibble_pkg: shared lane widths, derived nibble counts and FSM states
// for the nibble byte-lane transmit and capture sides.
package nibble_pkg;
  localparam int WORD_W_DEF = 16;
  localparam int NIB_W_DEF = 4;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int NW = WORD_W_DEF / NIB_W_DEF;
  localparam int NIDX_W = idx_w(NW);
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/nibble_word_fifo.sv
// nibble_word_fifo: small synchronous word buffer with registered full/empty
// flags, so downstream ready never reaches in_ready combinationally.
module nibble_word_fifo import nibble_pkg::*; #(
  parameter int W = WORD_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign cnt_n = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clock)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt_n;
      full <= cnt_n == (AW+1)'(DEPTH);
      empty <= cnt_n == '0;
    end
endmodule

// File: rtl/nibble_stream_tx.sv
// nibble_stream_tx: buffers signed words and serialises each onto a nibble
// lane with first/last markers and a running sent-word counter.
module nibble_stream_tx import nibble_pkg::*; #(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NIB_W = NIB_W_DEF,
  parameter int DEPTH = 2,
  parameter int MSN_FIRST = 0
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NIB_W-1:0]  out_nib,
  output logic              out_last,
  output logic              out_first,
  output logic              busy,
  output logic [15:0]       word_cnt
);
  localparam int NNIB = WORD_W / NIB_W;
  localparam int IW = idx_w(NNIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NNIB - 1);
  state_t state, state_n;
  logic [WORD_W-1:0] sh, sh_n, head;
  logic [IW-1:0] idx, idx_n;
  logic [15:0] cnt, cnt_n;
  logic alive, full, empty, accept, xfer, done, push, pop;
  nibble_word_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(in_data),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  // alive holds in_ready low until the first edge after reset release
  assign in_ready = alive && !full;
  assign accept = in_valid && in_ready;
  assign out_valid = state == SEND;
  assign xfer = out_valid && out_ready;
  assign done = xfer && idx == LAST_IDX;
  // an idle, empty path loads the word straight into the shifter
  assign push = accept && !(state == IDLE && empty);
  assign pop = !empty && (state == IDLE || done);
  assign out_nib = MSN_FIRST != 0 ? sh[WORD_W-1 -: NIB_W] : sh[NIB_W-1:0];
  assign out_first = out_valid && idx == '0;
  assign out_last = out_valid && idx == LAST_IDX;
  assign busy = out_valid || !empty;
  assign word_cnt = cnt;
  always_comb begin
    state_n = state;
    sh_n = sh;
    idx_n = idx;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (!empty || accept) begin
        state_n = SEND;
        sh_n = empty ? in_data : head;
        idx_n = '0;
      end
    end else if (xfer) begin
      sh_n = MSN_FIRST != 0 ? sh << NIB_W : sh >> NIB_W;
      idx_n = idx + 1'b1;
      if (done) begin
        cnt_n = cnt + 16'd1;
        idx_n = '0;
        sh_n = empty ? sh_n : head;
        state_n = empty ? IDLE : SEND;
      end
    end
  end
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      cnt <= '0;
      alive <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      idx <= idx_n;
      cnt <= cnt_n;
      alive <= 1'b1;
    end
endmodule

// File: tb/tb_nibble_stream_tx.sv
// tb_nibble_stream_tx: scenario tasks against a queue-based nibble model
// for both nibble orders.
module tb_nibble_stream_tx;
  localparam int NNIB = nibble_pkg::NW;
  logic clock = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, out_first, busy;
  logic [15:0] in_data = '0, word_cnt;
  logic [3:0] out_nib;
  logic m_in_valid = 1'b0, m_in_ready, m_out_valid, m_out_last, m_out_first, m_busy;
  logic [15:0] m_in_data = '0, m_word_cnt;
  logic [3:0] m_out_nib;
  int chk = 0, passed = 0, cyc = 0, gbase = 0;
  bit rand_mode = 0;
  logic [15:0] exp_words = '0;
  logic [5:0] exp_q[$], got_q[$];
  int got_cyc[$];

  nibble_stream_tx dut0 (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_nib(out_nib), .out_last(out_last),
    .out_first(out_first), .busy(busy), .word_cnt(word_cnt)
  );
  nibble_stream_tx #(.MSN_FIRST(1)) dut1 (
    .clock(clock), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(1'b1), .out_nib(m_out_nib), .out_last(m_out_last),
    .out_first(m_out_first), .busy(m_busy), .word_cnt(m_word_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock)
    if (rst && out_valid && out_ready) begin
      got_q.push_back({out_first, out_last, out_nib});
      got_cyc.push_back(cyc);
    end

  function automatic logic [3:0] nib_of(input logic [15:0] w, input int k, input bit msn);
    return msn ? 4'((w >> (12 - 4 * k)) & 16'hF) : 4'((w >> (4 * k)) & 16'hF);
  endfunction

  task automatic model_word(input logic [15:0] w);
    for (int k = 0; k < NNIB; k++) exp_q.push_back({k == 0, k == NNIB - 1, nib_of(w, k, 0)});
    exp_words = exp_words + 16'd1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [15:0] w, output int acc);
    in_data = w;
    in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      if (in_ready) begin
        tick();
        acc = cyc;
      end else tick();
    end
    in_valid = 1'b0;
    chk++;
    if (acc < 0) $display("FAIL send_word accept timeout word=%h", w);
    else begin
      passed++;
      model_word(w);
    end
  endtask

  task automatic wait_got(input int n, output bit ok);
    for (int t = 0; t < 2000 && got_q.size() < gbase + n; t++) tick();
    ok = got_q.size() >= gbase + n;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    chk++; if ({in_ready, out_valid, out_first, out_last, busy} !== 5'b0) $display("FAIL reset_flags got %b exp 00000", {in_ready, out_valid, out_first, out_last, busy}); else passed++;
    chk++; if (out_nib !== 4'h0) $display("FAIL reset_nib got %h exp 0", out_nib); else passed++;
    chk++; if (word_cnt !== 16'h0) $display("FAIL reset_cnt got %h exp 0", word_cnt); else passed++;
    rst = 1'b1;
    #1;
    chk++; if (in_ready !== 1'b0) $display("FAIL ready_before_edge got %b exp 0", in_ready); else passed++;
    tick();
    chk++; if (in_ready !== 1'b1) $display("FAIL ready_after_edge got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_single();
    int acc;
    bit ok;
    send_word(16'hFFDE, acc);
    wait_got(NNIB, ok);
    chk++;
    if (!ok) $display("FAIL single timeout got %0d nibbles exp %0d", got_q.size() - gbase, NNIB);
    else begin
      passed++;
      for (int i = 0; i < NNIB; i++) begin
        chk++; if (got_q[gbase + i] !== exp_q[i]) $display("FAIL single_nib%0d got %h exp %h", i, got_q[gbase + i], exp_q[i]); else passed++;
        chk++; if (got_cyc[gbase + i] !== acc + i) $display("FAIL single_cycle%0d got %0d exp %0d", i, got_cyc[gbase + i], acc + i); else passed++;
      end
      gbase += NNIB;
    end
    exp_q.delete();
    chk++; if (word_cnt !== exp_words) $display("FAIL single_cnt got %0d exp %0d", word_cnt, exp_words); else passed++;
    chk++; if ({out_valid, busy} !== 2'b00) $display("FAIL single_idle got %b exp 00", {out_valid, busy}); else passed++;
  endtask

  task automatic test_back_to_back();
    int acc0, acc;
    bit ok;
    send_word(16'h1234, acc0);
    send_word(16'hABCD, acc);
    send_word(16'h0001, acc);
    chk++; if (in_ready !== 1'b0) $display("FAIL b2b_full_ready got %b exp 0", in_ready); else passed++;
    wait_got(3 * NNIB, ok);
    chk++;
    if (!ok) $display("FAIL b2b timeout got %0d nibbles exp %0d", got_q.size() - gbase, 3 * NNIB);
    else begin
      passed++;
      for (int i = 0; i < 3 * NNIB; i++) begin
        chk++; if (got_q[gbase + i] !== exp_q[i]) $display("FAIL b2b_nib%0d got %h exp %h", i, got_q[gbase + i], exp_q[i]); else passed++;
        chk++; if (got_cyc[gbase + i] !== acc0 + i) $display("FAIL b2b_gap%0d got cycle %0d exp %0d", i, got_cyc[gbase + i], acc0 + i); else passed++;
      end
      gbase += 3 * NNIB;
    end
    exp_q.delete();
    chk++; if (word_cnt !== exp_words) $display("FAIL b2b_cnt got %0d exp %0d", word_cnt, exp_words); else passed++;
  endtask

  task automatic test_backpressure();
    int acc;
    logic [15:0] w = 16'h00F0;
    out_ready = 1'b1;
    send_word(w, acc);
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk++; if ({out_valid, out_first, out_nib} !== {2'b10, nib_of(w, 1, 0)}) $display("FAIL bp_hold%0d got %b_%h exp 10_%h", s, {out_valid, out_first}, out_nib, nib_of(w, 1, 0)); else passed++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    tick();
    chk++; if (word_cnt !== exp_words - 16'd1) $display("FAIL bp_cnt_early got %0d exp %0d", word_cnt, exp_words - 16'd1); else passed++;
    tick();
    chk++; if (word_cnt !== exp_words) $display("FAIL bp_cnt_done got %0d exp %0d", word_cnt, exp_words); else passed++;
    chk++;
    if (got_q.size() != gbase + NNIB) $display("FAIL bp_count got %0d nibbles exp %0d", got_q.size() - gbase, NNIB);
    else begin
      passed++;
      for (int i = 0; i < NNIB; i++) begin
        chk++; if (got_q[gbase + i] !== exp_q[i]) $display("FAIL bp_nib%0d got %h exp %h", i, got_q[gbase + i], exp_q[i]); else passed++;
      end
    end
    gbase = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_msn();
    logic [15:0] w = 16'h8001;
    chk++; if (m_in_ready !== 1'b1) $display("FAIL msn_ready got %b exp 1", m_in_ready); else passed++;
    m_in_data = w;
    m_in_valid = 1'b1;
    tick();
    m_in_valid = 1'b0;
    for (int k = 0; k < NNIB; k++) begin
      chk++;
      if ({m_out_valid, m_out_first, m_out_last, m_out_nib} !== {1'b1, k == 0, k == NNIB - 1, nib_of(w, k, 1)})
        $display("FAIL msn_nib%0d got v%b f%b l%b %h exp v1 f%b l%b %h", k, m_out_valid, m_out_first, m_out_last, m_out_nib, k == 0, k == NNIB - 1, nib_of(w, k, 1));
      else passed++;
      tick();
    end
    chk++; if (m_word_cnt !== 16'd1) $display("FAIL msn_cnt got %0d exp 1", m_word_cnt); else passed++;
  endtask

  task automatic test_random();
    int acc, total;
    bit ok;
    rand_mode = 1;
    for (int n = 0; n < 24; n++) begin
      send_word(16'($urandom), acc);
      repeat ($urandom_range(0, 2)) tick();
    end
    total = exp_q.size();
    wait_got(total, ok);
    rand_mode = 0;
    out_ready = 1'b1;
    chk++;
    if (!ok) $display("FAIL rand timeout got %0d nibbles exp %0d", got_q.size() - gbase, total);
    else begin
      passed++;
      for (int i = 0; i < total; i++) begin
        chk++; if (got_q[gbase + i] !== exp_q[i]) $display("FAIL rand_nib%0d got %h exp %h", i, got_q[gbase + i], exp_q[i]); else passed++;
      end
      gbase += total;
    end
    exp_q.delete();
    chk++; if (word_cnt !== exp_words) $display("FAIL rand_cnt got %0d exp %0d", word_cnt, exp_words); else passed++;
  endtask

  task automatic test_reset_mid();
    int acc;
    out_ready = 1'b1;
    send_word(16'h5A5A, acc);
    send_word(16'($urandom), acc);
    tick();
    rst = 1'b0;
    #1;
    chk++; if ({out_valid, busy, in_ready} !== 3'b000) $display("FAIL rstmid_flags got %b exp 000", {out_valid, busy, in_ready}); else passed++;
    chk++; if (word_cnt !== 16'h0) $display("FAIL rstmid_cnt got %0d exp 0", word_cnt); else passed++;
    @(posedge clock);
    #1;
    rst = 1'b1;
    #1;
    chk++; if (in_ready !== 1'b0) $display("FAIL rstmid_ready_early got %b exp 0", in_ready); else passed++;
    tick();
    chk++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", in_ready); else passed++;
    repeat (8) tick();
    chk++;
    if (got_q.size() != gbase + 2) $display("FAIL rstmid_residual got %0d nibbles exp 2", got_q.size() - gbase);
    else begin
      passed++;
      for (int i = 0; i < 2; i++) begin
        chk++; if (got_q[gbase + i] !== exp_q[i]) $display("FAIL rstmid_nib%0d got %h exp %h", i, got_q[gbase + i], exp_q[i]); else passed++;
      end
    end
    gbase = got_q.size();
    exp_q.delete();
    exp_words = '0;
  endtask

  task automatic test_wrap();
    int acc;
    bit ok;
    dut0.cnt = 16'hFFFF;
    exp_words = 16'hFFFF;
    send_word(16'($urandom), acc);
    wait_got(NNIB, ok);
    chk++; if (!ok) $display("FAIL wrap timeout got %0d nibbles exp %0d", got_q.size() - gbase, NNIB); else passed++;
    gbase = got_q.size();
    exp_q.delete();
    chk++; if (word_cnt !== exp_words) $display("FAIL wrap_cnt got %0d exp %0d", word_cnt, exp_words); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_msn();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, chk);
    $finish;
  end
endmodule
